// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, grant sources and bus widths.
// Imported by the top; no build macros affect this file.
package mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_ISSUE,
        RD_WAIT,
        RD_ACK
    } arb_state_t;

    typedef enum logic [1:0] {
        DBG,
        DWR,
        DRD,
        IRD
    } grant_src_t;

    function automatic logic src_is_write(input grant_src_t s);
        return (s == DBG) || (s == DWR);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for CPU instruction/data ports plus a debug write buffer.
// Define MEM_ARB_RR_EN to alternate grants between the data and instruction ports.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ins_rd_addr,
    input  logic              ins_rd_req,
    output logic              ins_rd_rdy,
    output logic [DATA_W-1:0] ins_rd_data,
    input  logic [ADDR_W-1:0] dat_rw_addr,
    input  logic              dat_rd_req,
    output logic              dat_rd_rdy,
    output logic [DATA_W-1:0] dat_rd_data,
    input  logic              dat_wr_req,
    input  logic [DATA_W-1:0] dat_wr_data,
    output logic              dat_wr_rdy,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    grant_src_t        r_src;
    grant_src_t        w_src;
    logic              w_grant;
    logic              w_dbg_grant;
    logic              w_dat_first;

    logic              r_dbg_vld;
    logic              r_dbg_ovf;
    logic [ADDR_W-1:0] r_dbg_addr;
    logic [DATA_W-1:0] r_dbg_data;

    logic              r_mem_re;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_ins_rdy;
    logic              r_drd_rdy;
    logic              r_dwr_rdy;
    logic [DATA_W-1:0] r_ins_data;
    logic [DATA_W-1:0] r_drd_data;

`ifdef MEM_ARB_RR_EN
    logic              r_last_ins;

    // Data side goes first unless the instruction port is waiting and data won last time.
    assign w_dat_first = !(ins_rd_req && !r_last_ins);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last_ins <= 1'b1;
        else if (w_grant && (w_src != DBG))
            r_last_ins <= (w_src == IRD);
    end
`else
    assign w_dat_first = 1'b1;
`endif

    assign w_dbg_grant = w_grant && (w_src == DBG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_grant     = 1'b0;
        w_src       = IRD;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_dbg_vld) begin
                    w_grant = 1'b1;
                    w_src   = DBG;
                end else if (dat_wr_req && w_dat_first) begin
                    w_grant = 1'b1;
                    w_src   = DWR;
                end else if (dat_rd_req && w_dat_first) begin
                    w_grant = 1'b1;
                    w_src   = DRD;
                end else if (ins_rd_req) begin
                    w_grant = 1'b1;
                    w_src   = IRD;
                end
                if (w_grant)
                    w_state_nxt = src_is_write(w_src) ? WR_ACK : RD_ISSUE;
            end
            WR_ACK:   w_state_nxt = IDLE;
            RD_ISSUE: w_state_nxt = RD_WAIT;
            RD_WAIT:  w_state_nxt = RD_ACK;
            RD_ACK:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // A new strobe always wins the buffer; a refill on the draining edge is not an overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbg_vld <= 1'b0;
            r_dbg_ovf <= 1'b0;
        end else begin
            if (dbg_we && r_dbg_vld && !w_dbg_grant)
                r_dbg_ovf <= 1'b1;
            if (dbg_we)
                r_dbg_vld <= 1'b1;
            else if (w_dbg_grant)
                r_dbg_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (dbg_we) begin
            r_dbg_addr <= dbg_waddr;
            r_dbg_data <= dbg_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src       <= IRD;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ins_rdy   <= 1'b0;
            r_drd_rdy   <= 1'b0;
            r_dwr_rdy   <= 1'b0;
            r_ins_data  <= '0;
            r_drd_data  <= '0;
        end else begin
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_ins_rdy <= 1'b0;
            r_drd_rdy <= 1'b0;
            r_dwr_rdy <= 1'b0;
            if (w_grant) begin
                r_src <= w_src;
                case (w_src)
                    DBG: begin
                        r_mem_addr  <= r_dbg_addr;
                        r_mem_wdata <= r_dbg_data;
                        r_mem_we    <= 1'b1;
                    end
                    DWR: begin
                        r_mem_addr  <= dat_rw_addr;
                        r_mem_wdata <= dat_wr_data;
                        r_mem_we    <= 1'b1;
                        r_dwr_rdy   <= 1'b1;
                    end
                    DRD: begin
                        r_mem_addr <= dat_rw_addr;
                        r_mem_re   <= 1'b1;
                    end
                    default: begin
                        r_mem_addr <= ins_rd_addr;
                        r_mem_re   <= 1'b1;
                    end
                endcase
            end
            // Memory returns data during RD_WAIT; hand it to whichever port was granted.
            if (r_state == RD_WAIT) begin
                if (r_src == IRD) begin
                    r_ins_data <= mem_rdata;
                    r_ins_rdy  <= 1'b1;
                end else begin
                    r_drd_data <= mem_rdata;
                    r_drd_rdy  <= 1'b1;
                end
            end
        end
    end

    assign ins_rd_rdy  = r_ins_rdy;
    assign ins_rd_data = r_ins_data;
    assign dat_rd_rdy  = r_drd_rdy;
    assign dat_rd_data = r_drd_data;
    assign dat_wr_rdy  = r_dwr_rdy;
    assign dbg_ovf     = r_dbg_ovf;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_re      = r_mem_re;
    assign mem_we      = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data, dbg_waddr, dbg_wdata;
    logic        ins_rd_req, dat_rd_req, dat_wr_req, dbg_we;
    logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, dbg_ovf, mem_re, mem_we;
    logic [15:0] ins_rd_data, dat_rd_data, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [69:0] all_outs;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req), .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
        .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req), .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
        .dat_wr_req(dat_wr_req), .dat_wr_data(dat_wr_data), .dat_wr_rdy(dat_wr_rdy),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata), .dbg_ovf(dbg_ovf),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign all_outs = {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, dbg_ovf, mem_re, mem_we,
                       mem_addr, mem_wdata, ins_rd_data, dat_rd_data};

    int n_vec = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {~a, a};
    endfunction

    // Memory attached to the DUT bus: read data one cycle after mem_re.
    logic [15:0] bmem [0:255];
    bit          bwr  [0:255];

    function automatic logic [15:0] bmem_rd(input logic [7:0] a);
        return bwr[a] ? bmem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= bmem_rd(mem_addr[7:0]);
        if (mem_we) begin
            bmem[mem_addr[7:0]] <= mem_wdata;
            bwr[mem_addr[7:0]]  <= 1'b1;
        end
    end

    // Reference model: busy countdown per transaction, golden memory updated at grant.
    logic [15:0] gold [0:255];
    logic        e_re = 0, e_we = 0, e_irdy = 0, e_drdy = 0, e_wrdy = 0, e_ovf = 0;
    logic [15:0] e_addr = 0, e_wdata = 0, e_idata = 0, e_ddata = 0;
    int          m_phase = 0;
    logic        m_rd_ins = 0, m_dv = 0, m_dat_first;
    logic [15:0] m_rd_addr = 0, m_da = 0, m_dd = 0;
`ifdef MEM_ARB_RR_EN
    logic        m_last_ins = 1'b1;
`endif

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = init_val(8'(i));
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                {e_re, e_we, e_irdy, e_drdy, e_wrdy, e_ovf} = '0;
                {e_addr, e_wdata, e_idata, e_ddata} = '0;
                m_phase = 0;
                m_dv    = 1'b0;
`ifdef MEM_ARB_RR_EN
                m_last_ins = 1'b1;
`endif
            end else begin
                {e_re, e_we, e_irdy, e_drdy, e_wrdy} = '0;
                if (m_phase == 0) begin
`ifdef MEM_ARB_RR_EN
                    m_dat_first = !(ins_rd_req && !m_last_ins);
`else
                    m_dat_first = 1'b1;
`endif
                    if (m_dv) begin
                        e_we = 1; e_addr = m_da; e_wdata = m_dd;
                        gold[m_da[7:0]] = m_dd; m_dv = 0; m_phase = 1;
                    end else if (dat_wr_req && m_dat_first) begin
                        e_we = 1; e_wrdy = 1; e_addr = dat_rw_addr; e_wdata = dat_wr_data;
                        gold[dat_rw_addr[7:0]] = dat_wr_data; m_phase = 1;
`ifdef MEM_ARB_RR_EN
                        m_last_ins = 1'b0;
`endif
                    end else if (dat_rd_req && m_dat_first) begin
                        e_re = 1; e_addr = dat_rw_addr; m_rd_ins = 0; m_rd_addr = dat_rw_addr; m_phase = 3;
`ifdef MEM_ARB_RR_EN
                        m_last_ins = 1'b0;
`endif
                    end else if (ins_rd_req) begin
                        e_re = 1; e_addr = ins_rd_addr; m_rd_ins = 1; m_rd_addr = ins_rd_addr; m_phase = 3;
`ifdef MEM_ARB_RR_EN
                        m_last_ins = 1'b1;
`endif
                    end
                end else begin
                    if (m_phase == 2) begin
                        if (m_rd_ins) begin e_irdy = 1; e_idata = gold[m_rd_addr[7:0]]; end
                        else          begin e_drdy = 1; e_ddata = gold[m_rd_addr[7:0]]; end
                    end
                    m_phase--;
                end
                if (dbg_we) begin
                    if (m_dv) e_ovf = 1'b1;
                    m_dv = 1'b1; m_da = dbg_waddr; m_dd = dbg_wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("bus",   80'({mem_re, mem_we, mem_addr, mem_wdata}), 80'({e_re, e_we, e_addr, e_wdata}));
            chk("rdy",   80'({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}), 80'({e_irdy, e_drdy, e_wrdy}));
            chk("rdata", 80'({ins_rd_data, dat_rd_data}), 80'({e_idata, e_ddata}));
            chk("ovf",   80'(dbg_ovf), 80'(e_ovf));
        end
    end

    task automatic ins_read(input logic [15:0] a, output logic [15:0] d, output int lat);
        ins_rd_addr = a; ins_rd_req = 1'b1; lat = 0; d = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ins_rd_rdy) begin lat = k; d = ins_rd_data; break; end
        end
        ins_rd_req = 1'b0;
        chk("ins_done", 80'(lat != 0), 80'(1));
    endtask

    task automatic dat_xfer(input logic [15:0] a, input logic [15:0] wd, input logic wr, input logic rd,
                            output logic [15:0] d, output int wlat, output int rlat);
        dat_rw_addr = a; dat_wr_data = wd; dat_wr_req = wr; dat_rd_req = rd;
        wlat = 0; rlat = 0; d = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dat_wr_req && dat_wr_rdy) begin wlat = k; dat_wr_req = 1'b0; end
            if (dat_rd_req && dat_rd_rdy) begin rlat = k; d = dat_rd_data; dat_rd_req = 1'b0; end
            if (!dat_wr_req && !dat_rd_req) break;
        end
        chk("dat_done", 80'({dat_wr_req, dat_rd_req}), 80'(0));
        dat_wr_req = 1'b0; dat_rd_req = 1'b0;
    endtask

    task automatic dbg_pulse(input logic [15:0] a, input logic [15:0] d);
        dbg_waddr = a; dbg_wdata = d; dbg_we = 1'b1;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          lat, wl, rl, got;
        logic [17:0] first_op;
        logic [15:0] rr_q[$];

        reset = 1'b1;
        {ins_rd_req, dat_rd_req, dat_wr_req, dbg_we} = '0;
        {ins_rd_addr, dat_rw_addr, dat_wr_data, dbg_waddr, dbg_wdata} = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 80'(all_outs), 80'(0));
        reset  = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Instruction read of a preloaded word.
        fork
            ins_read(16'h0010, d, lat);
            begin
                @(negedge clk);
                chk("ird_issue", 80'({mem_re, mem_we, mem_addr}), 80'({1'b1, 1'b0, 16'h0010}));
            end
        join
        chk("ird_lat", 80'(lat), 80'(3));
        chk("ird_data", 80'(d), 80'(16'h1234));
        @(negedge clk);

        // Simultaneous data write and read to the same address: write wins.
        dat_xfer(16'h0020, 16'hBEEF, 1'b1, 1'b1, d, wl, rl);
        chk("dwr_lat", 80'(wl), 80'(1));
        chk("drd_lat", 80'(rl), 80'(5));
        chk("drd_data", 80'(d), 80'(16'hBEEF));
        @(negedge clk);

        // Debug write during an instruction read is served before the next CPU grant.
        fork
            ins_read(16'h0011, d, lat);
            begin @(negedge clk); dbg_pulse(16'h0005, 16'hAAAA); end
        join
        chk("ird_data2", 80'(d), 80'(init_val(8'h11)));
        first_op = '0;
        fork
            ins_read(16'h0005, d, lat);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (mem_re || mem_we) begin first_op = {mem_we, mem_re, mem_addr}; break; end
            end
        join
        chk("dbg_first", 80'(first_op), 80'({1'b1, 1'b0, 16'h0005}));
        chk("dbg_value", 80'(d), 80'(16'hAAAA));
        chk("ovf_quiet", 80'(dbg_ovf), 80'(0));
        @(negedge clk);

        // Two debug strobes inside one read: the second survives and overflow sticks.
        fork
            ins_read(16'h0012, d, lat);
            begin
                @(negedge clk);
                dbg_waddr = 16'h0006; dbg_wdata = 16'h1111; dbg_we = 1'b1;
                @(negedge clk);
                dbg_wdata = 16'h2222;
                @(negedge clk);
                dbg_we = 1'b0;
            end
        join
        ins_read(16'h0006, d, lat);
        chk("ovf_value", 80'(d), 80'(16'h2222));
        chk("ovf_set", 80'(dbg_ovf), 80'(1));
        @(negedge clk);

        // Reset while the read is waiting on memory.
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        @(negedge clk);
        chk("rst_issue", 80'(mem_re), 80'(1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_async", 80'(all_outs), 80'(0));
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        got = 0; d = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ins_rd_rdy) begin got = 1; d = ins_rd_data; break; end
        end
        ins_rd_req = 1'b0;
        chk("rst_recover_rdy", 80'(got), 80'(1));
        chk("rst_recover_data", 80'(d), 80'(16'h1234));
        chk("rst_ovf_clr", 80'(dbg_ovf), 80'(0));
        @(negedge clk);

        // Randomized traffic on all three ports.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (ins_rd_req) begin
                if (ins_rd_rdy) ins_rd_req = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                ins_rd_addr = 16'($urandom_range(15));
                ins_rd_req  = 1'b1;
            end
            if (dat_wr_req && dat_wr_rdy) dat_wr_req = 1'b0;
            if (dat_rd_req && dat_rd_rdy) dat_rd_req = 1'b0;
            if (!dat_wr_req && !dat_rd_req && $urandom_range(3) == 0) begin
                dat_rw_addr = 16'($urandom_range(15));
                dat_wr_data = 16'($urandom);
                dat_wr_req  = 1'($urandom_range(1));
                dat_rd_req  = !dat_wr_req || 1'($urandom_range(1));
            end
            dbg_we = ($urandom_range(11) == 0);
            if (dbg_we) begin
                dbg_waddr = 16'($urandom_range(15));
                dbg_wdata = 16'($urandom);
            end
        end
        @(negedge clk);
        {ins_rd_req, dat_rd_req, dat_wr_req, dbg_we} = '0;
        repeat (10) @(negedge clk);
        for (int a = 0; a < 64; a++)
            chk("mem_image", 80'(bmem_rd(8'(a))), 80'(gold[a]));

        // Continuous instruction and data reads from a fresh reset.
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        ins_rd_addr = 16'h0030; dat_rw_addr = 16'h0031;
        ins_rd_req = 1'b1; dat_rd_req = 1'b1;
        for (int k = 0; k < 40 && rr_q.size() < 4; k++) begin
            @(negedge clk);
            if (mem_re) rr_q.push_back(mem_addr);
        end
        ins_rd_req = 1'b0; dat_rd_req = 1'b0;
        chk("rr_count", 80'(rr_q.size()), 80'(4));
        for (int i = 0; i < rr_q.size(); i++) begin
`ifdef MEM_ARB_RR_EN
            chk("rr_order", 80'(rr_q[i]), 80'((i % 2 == 0) ? 16'h0031 : 16'h0030));
`else
            chk("fixed_order", 80'(rr_q[i]), 80'(16'h0031));
`endif
        end
        repeat (6) @(negedge clk);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk  in  1  single clock for all logic.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port ins_rd_addr  in  16  CPU instruction read address.
REQ-004 SHALL have port ins_rd_req  in  1  instruction read request, held until ins_rd_rdy.
REQ-005 SHALL have port ins_rd_rdy  out  1  one-cycle read-complete pulse.
REQ-006 SHALL have port ins_rd_data  out  16  instruction data, valid while ins_rd_rdy=1.
REQ-007 SHALL have port dat_rw_addr  in  16  CPU data read/write address.
REQ-008 SHALL have port dat_rd_req  in  1  data read request, held until dat_rd_rdy.
REQ-009 SHALL have port dat_rd_rdy  out  1  one-cycle read-complete pulse.
REQ-010 SHALL have port dat_rd_data  out  16  read data, valid while dat_rd_rdy=1.
REQ-011 SHALL have port dat_wr_req  in  1  data write request, held until dat_wr_rdy.
REQ-012 SHALL have port dat_wr_data  in  16  write data.
REQ-013 SHALL have port dat_wr_rdy  out  1  one-cycle write-accepted pulse.
REQ-014 SHALL have port dbg_we  in  1  debug write strobe, one cycle, never stalled.
REQ-015 SHALL have port dbg_waddr / dbg_wdata  in  16/16  debug write address/data.
REQ-016 SHALL have port dbg_ovf  out  1  sticky: debug write overwritten before service.
REQ-017 SHALL have port mem_addr / mem_wdata  out  16/16  registered memory address/data.
REQ-018 SHALL have port mem_re / mem_we  out  1/1  registered memory read/write enables.
REQ-019 SHALL have port mem_rdata  in  16  memory data, valid the cycle after mem_re.

Function
REQ-020 SHALL use FSM states IDLE, WR_ACK, RD_ISSUE, RD_WAIT, RD_ACK; only IDLE samples requests.
REQ-021 SHALL, in IDLE, grant by fixed priority: pending debug > dat_wr > dat_rd > ins_rd; dat_wr beats simultaneous dat_rd.
REQ-022 SHALL, on a write grant at edge E0, register mem_addr/mem_wdata, mem_we=1 and the matching rdy=1 for one cycle (WR_ACK), then return to IDLE at E1.
REQ-023 SHALL, on a read grant at E0, drive mem_re=1 for one cycle (RD_ISSUE); at E2 capture mem_rdata into the port's rd_data and pulse rdy (RD_ACK); return to IDLE at E3.
REQ-024 SHALL give rdy latencies: write 1 cycle and read 3 cycles from the grant edge; throughput one transaction per 2 (write) or 4 (read) cycles.
REQ-025 SHALL keep mem_re/mem_we 0 outside RD_ISSUE/WR_ACK and never assert both.
REQ-026 SHALL latch dbg_we into a one-entry pending buffer (addr, data, valid) in any state; it is served as a write at the next IDLE, with no rdy output.
REQ-027 SHALL, on dbg_we while pending is valid and not being granted that edge, overwrite the buffer and set dbg_ovf; dbg_we coincident with grant of the pending entry refills the buffer with no overflow.
REQ-028 SHALL hold rd_data outputs stable between rdy pulses.

Reset
REQ-029 SHALL asynchronously force state=IDLE, all rdy=0, mem_re=mem_we=0, mem_addr=mem_wdata=0, rd_data outputs=0, pending valid=0, dbg_ovf=0; an in-flight transaction is abandoned without a rdy.
REQ-030 SHALL clear dbg_ovf only by reset.

Configuration
REQ-031 SHALL, with MEM_ARB_RR_EN defined, alternate CPU grants: when both a data request and ins_rd_req are present, the port not granted last wins; debug keeps top priority; dat_wr still beats dat_rd.
REQ-032 SHALL, without MEM_ARB_RR_EN, use the fixed priority of REQ-021 only.

Structure
REQ-033 SHALL place the FSM state enum and grant-source enum (DBG, DWR, DRD, IRD) in a shared package.
REQ-034 SHALL be a single module with no sub-modules; the debug pending buffer is inline.

Verification
REQ-035 SHALL cover: ins_rd_req, addr 0x0010 holding 0x1234 -> mem_re pulse next cycle, ins_rd_rdy with ins_rd_data=0x1234 3 cycles after grant.
REQ-036 SHALL cover: dat_wr_req and dat_rd_req together, addr 0x0020, data 0xBEEF -> write first (dat_wr_rdy), read then returns 0xBEEF.
REQ-037 SHALL cover: dbg_we (0x0005, 0xAAAA) during an ins read -> read completes, then mem_we to 0x0005 before the next CPU grant; dbg_ovf=0.
REQ-038 SHALL cover: two dbg_we within one read transaction -> second value written, dbg_ovf=1.
REQ-039 SHALL cover: reset asserted in RD_WAIT -> all outputs 0 immediately, no rdy, next request served normally.
REQ-040 SHALL cover (MEM_ARB_RR_EN): ins_rd_req and dat_rd_req held continuously -> grants alternate dat, ins, dat, ins.
